mio_bus_responder: RTL and testbench
====================================

Name: mio_bus_responder

Overview:
- Memory/IO bus responder on the far end of the control unit's CPU_MIO / MIO_ready handshake.
- Accepts one CPU load/store request at a time and decodes the address into one of three regions: data RAM, seven-segment display register, or LED/switch GPIO.
- Performs the access with a fixed wait latency, then pulses MIO_ready so the stalled single-cycle CPU can proceed.

Parameters:
WAIT_CYCLES, 2, cycles spent in ACCESS per request; values below 2 are clamped to 2 because the RAM read has 1-cycle latency.
RAM_AW, 10, RAM word-address width.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
CPU_MIO  in  1  CPU memory/IO request.
mem_w  in  1  1 = store, 0 = load; sampled with CPU_MIO.
addr_bus  in  32  CPU byte address.
Data_out  in  32  CPU store data.
Data_in  out  32  load data returned to CPU.
MIO_ready  out  1  one-cycle completion pulse.
ram_we  out  1  RAM write strobe.
ram_addr  out  RAM_AW  RAM word address.
ram_din  out  32  RAM write data.
ram_dout  in  32  RAM read data, valid one cycle after ram_addr.
sw_in  in  16  switch inputs.
led_out  out  16  LED register.
disp_data  out  32  seven-segment display register.

Behaviour:
- Reset values: all outputs 0; state IDLE; wait counter 0.
- FSM states are IDLE, ACCESS and READY.
  - IDLE: when CPU_MIO=1 at a clock edge, latch addr_bus, Data_out and mem_w, clear the counter, and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: the counter increments every cycle. At the edge where counter==WAIT_CYCLES-1, commit the access and go to READY.
  - READY: MIO_ready=1 for exactly this cycle. Unconditionally return to IDLE at the next edge.
- Latency: with acceptance edge E0, MIO_ready is high from edge E(WAIT_CYCLES) to E(WAIT_CYCLES+1).
- Region decode uses the latched addr[31:28]:
  - 4'h0 = RAM, word address addr[RAM_AW+1:2].
  - 4'hE = display.
  - 4'hF with addr[2]=0 = GPIO.
  - Anything else is unmapped.
- RAM:
  - ram_addr is driven from the latched address throughout ACCESS.
  - ram_we=1 only in the first ACCESS cycle of a store; ram_din = latched data.
  - On a load, Data_in <= ram_dout at the commit edge.
- Display: a store writes disp_data at the commit edge. A load returns disp_data.
- GPIO: a store writes led_out <= data[15:0]. A load returns {16'h0, sw_in}, sampled at the commit edge.
- Unmapped: a store is dropped; a load returns 32'h0. MIO_ready still pulses.
- Data_in is updated only by loads and holds its value across stores.
- CPU_MIO dropped during ACCESS: the access still completes and MIO_ready still pulses.
- CPU_MIO high during READY is ignored. A new request is accepted only in IDLE, so there is at least one cycle between back-to-back requests.
- Reset mid-access aborts it: no MIO_ready, ram_we forced 0, led_out/disp_data/Data_in cleared.
- Address bits [1:0] are ignored; all accesses are full-word.

Optional Feature:
- Macro MIO_BUSERR_EN.
- When defined, an extra output port bus_err (1 bit) asserts together with MIO_ready on any unmapped access. Its reset value is 0.
- When undefined, the port does not exist and unmapped accesses complete silently.

Decomposition:
- Package mio_pkg holds:
  - region codes REG_RAM=4'h0, REG_DISP=4'hE, REG_GPIO=4'hF;
  - the state encoding IDLE/ACCESS/READY;
  - the minimum wait constant 2.
- One sub-module, mio_addr_decode: purely combinational; latched address in, one-hot region select plus RAM word address out.

Test Plan:
1. RAM store then load: store Data_out=32'hDEADBEEF to addr 32'h00000010; expect ram_we pulse with ram_addr=4 and MIO_ready at +2 cycles. Then load the same address with the RAM model returning DEADBEEF; expect Data_in=32'hDEADBEEF with the MIO_ready pulse.
2. GPIO: store 32'h0000A5A5 to 32'hF0000000 -> led_out=16'hA5A5. Load from 32'hF0000000 with sw_in=16'h1234 -> Data_in=32'h00001234.
3. Display: store 32'h12345678 to 32'hE0000000 -> disp_data=32'h12345678. A following load from the same address returns 32'h12345678.
4. Unmapped load from 32'h80000000 -> Data_in=0 and MIO_ready still pulses. With MIO_BUSERR_EN defined, bus_err=1 in the same cycle.
5. CPU_MIO held high continuously across two requests -> MIO_ready pulses spaced WAIT_CYCLES+2 cycles apart. Repeat with WAIT_CYCLES=4 and confirm the pulse at +4.
6. Assert rst_n=0 during ACCESS of a store to the LEDs -> no MIO_ready, led_out=0. After release, state is IDLE and the next request completes normally.

Source files
------------

// File: rtl/mio_bus_responder_pkg.sv
// Shared definitions for the MIO bus responder: region codes, FSM encoding,
// one-hot select indices and the minimum access latency.
package mio_pkg;

  localparam logic [3:0] REG_RAM  = 4'h0;
  localparam logic [3:0] REG_DISP = 4'hE;
  localparam logic [3:0] REG_GPIO = 4'hF;

  // The RAM read takes one cycle, so an access cannot commit sooner than this
  localparam int MIN_WAIT = 2;

  localparam int SEL_RAM  = 0;
  localparam int SEL_DISP = 1;
  localparam int SEL_GPIO = 2;
  localparam int SEL_W    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    READY  = 2'd2
  } mio_state_e;

  function automatic logic is_ram_region(input logic [31:0] addr);
    return (addr[31:28] == REG_RAM);
  endfunction

endpackage

// File: rtl/mio_bus_responder_addr_decode.sv
// Combinational region decode of the latched CPU address into a one-hot
// select (RAM / display / GPIO) plus the RAM word address.
module mio_addr_decode
  import mio_pkg::*;
#(
  parameter int RAM_AW = 10
) (
  input  logic [31:0]       addr,
  output logic [SEL_W-1:0]  sel,
  output logic [RAM_AW-1:0] word_addr
);

  logic unused_bits_s;

  // Region select; all-zero means the address is unmapped
  always_comb begin
    sel = '0;
    case (addr[31:28])
      REG_RAM:  sel[SEL_RAM]  = 1'b1;
      REG_DISP: sel[SEL_DISP] = 1'b1;
      REG_GPIO: begin
        if (addr[2] == 1'b0) begin
          sel[SEL_GPIO] = 1'b1;
        end else begin
          sel = '0;
        end
      end
      default:  sel = '0;
    endcase
  end

  assign word_addr     = addr[RAM_AW+1:2];
  assign unused_bits_s = ^{addr[1:0], addr[27:RAM_AW+2]};

endmodule

// File: rtl/mio_bus_responder.sv
// MIO bus responder: serves one CPU load/store at a time with fixed latency
// and pulses MIO_ready. Define MIO_BUSERR_EN to add the bus_err output.
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int RAM_AW      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       addr_bus,
  input  logic [31:0]       Data_out,
  output logic [31:0]       Data_in,
  output logic              MIO_ready,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw_in,
  output logic [15:0]       led_out,
  output logic [31:0]       disp_data
`ifdef MIO_BUSERR_EN
  ,
  output logic              bus_err
`endif
);

  localparam int WAIT_EFF = (WAIT_CYCLES < MIN_WAIT) ? MIN_WAIT : WAIT_CYCLES;
  localparam int CNT_W    = $clog2(WAIT_EFF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_EFF - 1);

  mio_state_e        state_r, state_s;
  logic [31:0]       addr_r, data_r, data_in_r, disp_r, rd_data_s;
  logic              mem_w_r, mio_ready_r, ram_we_r, accept_s, commit_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [15:0]       led_r;
  logic [SEL_W-1:0]  sel_s;
  logic [RAM_AW-1:0] word_addr_s;

  mio_addr_decode #(.RAM_AW(RAM_AW)) u_decode (
    .addr      (addr_r),
    .sel       (sel_s),
    .word_addr (word_addr_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state plus accept/commit strobes
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (CPU_MIO) begin
          state_s  = ACCESS;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_r == CNT_LAST) begin
          state_s  = READY;
          commit_s = 1'b1;
        end else begin
          state_s = ACCESS;
        end
      end
      READY:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Load data source for the decoded region
  always_comb begin
    rd_data_s = 32'h0000_0000;
    if (sel_s[SEL_RAM]) begin
      rd_data_s = ram_dout;
    end else if (sel_s[SEL_DISP]) begin
      rd_data_s = disp_r;
    end else if (sel_s[SEL_GPIO]) begin
      rd_data_s = {16'h0000, sw_in};
    end else begin
      rd_data_s = 32'h0000_0000;
    end
  end

  // Request latch, wait counter and access commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r      <= 32'h0000_0000;
      data_r      <= 32'h0000_0000;
      mem_w_r     <= 1'b0;
      cnt_r       <= '0;
      ram_we_r    <= 1'b0;
      mio_ready_r <= 1'b0;
      data_in_r   <= 32'h0000_0000;
      disp_r      <= 32'h0000_0000;
      led_r       <= 16'h0000;
    end else begin
      mio_ready_r <= commit_s;
      if (accept_s) begin
        addr_r   <= addr_bus;
        data_r   <= Data_out;
        mem_w_r  <= mem_w;
        cnt_r    <= '0;
        // Pre-decoded so the strobe is a register during the first ACCESS cycle
        ram_we_r <= mem_w & is_ram_region(addr_bus);
      end else if (state_r == ACCESS) begin
        cnt_r    <= cnt_r + CNT_W'(1);
        ram_we_r <= 1'b0;
      end else begin
        ram_we_r <= 1'b0;
      end
      if (commit_s) begin
        if (mem_w_r) begin
          if (sel_s[SEL_DISP]) begin
            disp_r <= data_r;
          end else if (sel_s[SEL_GPIO]) begin
            led_r <= data_r[15:0];
          end
        end else begin
          data_in_r <= rd_data_s;
        end
      end
    end
  end

`ifdef MIO_BUSERR_EN
  logic bus_err_r;

  // Error flag rides alongside the completion pulse for unmapped accesses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_err_r <= 1'b0;
    end else begin
      bus_err_r <= commit_s & ~(|sel_s);
    end
  end

  assign bus_err = bus_err_r;
`endif

  assign Data_in   = data_in_r;
  assign MIO_ready = mio_ready_r;
  assign ram_we    = ram_we_r;
  assign ram_addr  = word_addr_s;
  assign ram_din   = data_r;
  assign led_out   = led_r;
  assign disp_data = disp_r;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Scoreboard bench for mio_bus_responder (WAIT_CYCLES=2 main instance plus a
// WAIT_CYCLES=4 instance for latency); honours MIO_BUSERR_EN.
module tb_mio_bus_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          rdy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_mio = 1'b0, cpu_mio4 = 1'b0, mem_w = 1'b0;
  logic [31:0] addr_bus = 32'h0, data_out = 32'h0;
  logic [15:0] sw_in = 16'h0;
  logic [31:0] data_in, ram_din, ram_dout, disp_data;
  logic        mio_ready, ram_we;
  logic [9:0]  ram_addr;
  logic [15:0] led_out;
  logic [31:0] data_in4, ram_din4, disp_data4;
  logic        mio_ready4, ram_we4;
  logic [9:0]  ram_addr4;
  logic [15:0] led_out4;
  logic [31:0] ram_dout4 = 32'h0;
`ifdef MIO_BUSERR_EN
  logic        bus_err, bus_err4;
`endif

  logic [31:0] ram_mem [0:1023];
  exp_t        q[$], q4[$];
  exp_t        e_mon, e_mon4;
  int          cyc = 0;
  int          n_chk = 0, n_pass = 0;
  logic [31:0] last_m = 32'h0, disp_m = 32'h0;
  logic [15:0] led_m = 16'h0;

  mio_bus_responder #(.WAIT_CYCLES(2), .RAM_AW(10)) dut (
    .clk(clk), .rst_n(rst_n), .CPU_MIO(cpu_mio), .mem_w(mem_w),
    .addr_bus(addr_bus), .Data_out(data_out), .Data_in(data_in),
    .MIO_ready(mio_ready), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .sw_in(sw_in),
    .led_out(led_out), .disp_data(disp_data)
`ifdef MIO_BUSERR_EN
    , .bus_err(bus_err)
`endif
  );

  mio_bus_responder #(.WAIT_CYCLES(4), .RAM_AW(10)) dut4 (
    .clk(clk), .rst_n(rst_n), .CPU_MIO(cpu_mio4), .mem_w(mem_w),
    .addr_bus(addr_bus), .Data_out(data_out), .Data_in(data_in4),
    .MIO_ready(mio_ready4), .ram_we(ram_we4), .ram_addr(ram_addr4),
    .ram_din(ram_din4), .ram_dout(ram_dout4), .sw_in(sw_in),
    .led_out(led_out4), .disp_data(disp_data4)
`ifdef MIO_BUSERR_EN
    , .bus_err(bus_err4)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM with one-cycle read latency
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Completion monitor for the WAIT_CYCLES=2 instance
  always @(negedge clk) begin
    if (rst_n && mio_ready === 1'b1) begin
      if (q.size() == 0) begin
        check("ready_expected", 32'(q.size() > 0), 32'd1);
      end else begin
        e_mon = q.pop_front();
        check("data_in", data_in, e_mon.data);
        check("ready_cyc", cyc, e_mon.rdy);
`ifdef MIO_BUSERR_EN
        check("bus_err", 32'(bus_err), 32'(e_mon.err));
`endif
      end
    end
  end

  // Completion monitor for the WAIT_CYCLES=4 instance
  always @(negedge clk) begin
    if (rst_n && mio_ready4 === 1'b1) begin
      if (q4.size() == 0) begin
        check("ready4_expected", 32'(q4.size() > 0), 32'd1);
      end else begin
        e_mon4 = q4.pop_front();
        check("data_in4", data_in4, e_mon4.data);
        check("ready4_cyc", cyc, e_mon4.rdy);
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (q.size() == 0 && q4.size() == 0) break;
    end
    check("timeout_pending", 32'(q.size() + q4.size()), 32'd0);
  endtask

  task automatic req(input logic st, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic err, input logic exp_we);
    @(negedge clk);
    cpu_mio = 1'b1; mem_w = st; addr_bus = a; data_out = d;
    @(posedge clk); #1;
    cpu_mio = 1'b0;
    check("ram_we", 32'(ram_we), 32'(exp_we));
    if (exp_we) begin
      check("ram_addr", 32'(ram_addr), 32'(a[11:2]));
      check("ram_din", ram_din, d);
    end
    if (!st) last_m = exp_rd;
    q.push_back('{data: last_m, err: err, rdy: cyc + 2});
    wait_done();
  endtask

  initial begin
    int c0;
    for (int i = 0; i < 1024; i++) ram_mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_data_in", data_in, 32'h0);
    check("rst_ready", 32'(mio_ready), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_ram_addr", 32'(ram_addr), 32'h0);
    check("rst_led", 32'(led_out), 32'h0);
    check("rst_disp", disp_data, 32'h0);
`ifdef MIO_BUSERR_EN
    check("rst_bus_err", 32'(bus_err), 32'h0);
`endif
    rst_n = 1'b1;

    // RAM store, load, and load with ignored low address bits
    req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
    req(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    req(1'b0, 32'h0000_0013, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // GPIO, including the unmapped addr[2]=1 hole
    req(1'b1, 32'hF000_0000, 32'h0000_A5A5, 32'h0, 1'b0, 1'b0);
    led_m = 16'hA5A5;
    check("led_store", 32'(led_out), 32'(led_m));
    req(1'b1, 32'hF000_0004, 32'h0000_FFFF, 32'h0, 1'b1, 1'b0);
    check("led_hole", 32'(led_out), 32'(led_m));
    sw_in = 16'h1234;
    req(1'b0, 32'hF000_0000, 32'h0, 32'h0000_1234, 1'b0, 1'b0);

    // Display
    req(1'b1, 32'hE000_0000, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    disp_m = 32'h1234_5678;
    check("disp_store", disp_data, disp_m);
    req(1'b0, 32'hE000_0000, 32'h0, disp_m, 1'b0, 1'b0);

    // Unmapped load
    req(1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 1'b0);

    // CPU_MIO held across two requests on both latencies
    @(negedge clk);
    cpu_mio = 1'b1; cpu_mio4 = 1'b1; mem_w = 1'b0; addr_bus = 32'hE000_0000;
    @(posedge clk); #1;
    c0 = cyc;
    last_m = disp_m;
    q.push_back('{data: disp_m, err: 1'b0, rdy: c0 + 2});
    q.push_back('{data: disp_m, err: 1'b0, rdy: c0 + 6});
    q4.push_back('{data: 32'h0, err: 1'b0, rdy: c0 + 4});
    q4.push_back('{data: 32'h0, err: 1'b0, rdy: c0 + 10});
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (cyc >= c0 + 6) cpu_mio = 1'b0;
      if (cyc >= c0 + 10) cpu_mio4 = 1'b0;
    end
    cpu_mio = 1'b0; cpu_mio4 = 1'b0;
    wait_done();

    // Reset in the middle of an LED store
    @(negedge clk);
    cpu_mio = 1'b1; mem_w = 1'b1; addr_bus = 32'hF000_0000; data_out = 32'h0000_5A5A;
    @(posedge clk); #1;
    cpu_mio = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    led_m = 16'h0; disp_m = 32'h0; last_m = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_ready", 32'(mio_ready), 32'h0);
    end
    check("rst_mid_led", 32'(led_out), 32'h0);
    check("rst_mid_ram_we", 32'(ram_we), 32'h0);
    check("rst_mid_disp", disp_data, 32'h0);
    check("rst_mid_data_in", data_in, 32'h0);
    rst_n = 1'b1;
    req(1'b0, 32'hF000_0000, 32'h0, 32'h0000_1234, 1'b0, 1'b0);
    req(1'b1, 32'hF000_0000, 32'h0000_0F0F, 32'h0, 1'b0, 1'b0);
    led_m = 16'h0F0F;
    check("led_after_rst", 32'(led_out), 32'(led_m));

    repeat (4) @(negedge clk);
    check("q_drained", 32'(q.size() + q4.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
